pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_fetch_if.sv | 24 ++
 rtl/pc_next_sel.sv | 41 ++++
 rtl/pc_fetch.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: the NOP used as a
// bubble, the default reset fetch address and the fetch state encoding.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus. The fetch unit is the master,
// the instruction memory the slave.
interface pc_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/pc_next_sel.sv
// Next fetch address selection: csr redirect over branch redirect over
// sequential advance over hold. Without PC_FETCH_MISALIGN_EN the low two
// target bits are cleared; with it, a misaligned target is flagged instead.
module pc_next_sel
   import fetch_pkg::*;
(
   input  logic [31:0] fetch_pc_i,
   input  logic        advance_i,
   input  logic        csr_flush_i,
   input  logic [31:0] csr_target_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
`ifdef PC_FETCH_MISALIGN_EN
   output logic        misalign_o,
`endif
   output logic        redirect_o,
   output logic [31:0] next_pc_o
);

   logic [31:0] raw_target;
   logic [31:0] target;

   // Pick the redirect source and the address the next request will use.
   always_comb begin
      raw_target = csr_flush_i ? csr_target_i : br_target_i;
      redirect_o = csr_flush_i | br_taken_i;
`ifdef PC_FETCH_MISALIGN_EN
      target     = raw_target;
      misalign_o = redirect_o && (raw_target[1:0] != 2'b00);
`else
      target     = raw_target & 32'hFFFF_FFFC;
`endif
      if (redirect_o)
         next_pc_o = target;
      else if (advance_i)
         next_pc_o = fetch_pc_i + 32'd4;
      else
         next_pc_o = fetch_pc_i;
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: one outstanding imem request, a 1-entry hold
// buffer for words arriving under Stall, and the Fetch_Reg output registers.
// Optional macro PC_FETCH_MISALIGN_EN adds the fetch_misalign output.
//
//   state | meaning
//   IDLE  | no request; one cycle after reset, or parked after a misaligned redirect
//   REQ   | imem_req high at imem_addr, waiting for imem_ack
//   HOLD  | word captured under Stall, waiting for Stall to drop
module pc_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        csr_flush,
   input  logic [31:0] csr_target,
   pc_fetch_if.master  imem,
`ifdef PC_FETCH_MISALIGN_EN
   output logic        fetch_misalign,
`endif
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        fetch_valid
);

   fetch_state_e state_q;
   logic [31:0]  fetch_pc_q;
   logic         drop_q;
   logic [31:0]  drop_addr_q;
   logic [31:0]  buf_pc_q;
   logic [31:0]  buf_instr_q;
   logic [31:0]  pc_q;
   logic [31:0]  instr_q;
   logic         valid_q;
`ifdef PC_FETCH_MISALIGN_EN
   logic         misalign_q;
   logic         wait_q;
   logic         misalign;
`endif

   logic         in_req;
   logic         advance;
   logic         redirect;
   logic [31:0]  fetch_pc_d;

   assign in_req  = (state_q == REQ);
   assign advance = (in_req && imem.imem_ack && !drop_q && !Stall)
                 || (state_q == HOLD && !Stall);

   pc_next_sel u_next_sel (
      .fetch_pc_i   (fetch_pc_q),
      .advance_i    (advance),
      .csr_flush_i  (csr_flush),
      .csr_target_i (csr_target),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
`ifdef PC_FETCH_MISALIGN_EN
      .misalign_o   (misalign),
`endif
      .redirect_o   (redirect),
      .next_pc_o    (fetch_pc_d)
   );

   // While a dropped request is still in flight its address must stay on
   // the bus; the redirect target is only requested once that ack arrives.
   assign imem.imem_req  = in_req;
   assign imem.imem_addr = drop_q ? drop_addr_q : fetch_pc_q;

   assign PC          = pc_q;
   assign Instruction = instr_q;
   assign fetch_valid = valid_q;
`ifdef PC_FETCH_MISALIGN_EN
   assign fetch_misalign = misalign_q;
`endif

   // Fetch FSM, drop tracking, hold buffer and Fetch_Reg output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_q      <= 1'b0;
         drop_addr_q <= 32'h0;
         buf_pc_q    <= 32'h0;
         buf_instr_q <= NOP_INSTR;
         pc_q        <= 32'h0;
         instr_q     <= NOP_INSTR;
         valid_q     <= 1'b0;
`ifdef PC_FETCH_MISALIGN_EN
         misalign_q  <= 1'b0;
         wait_q      <= 1'b0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
`ifdef PC_FETCH_MISALIGN_EN
         misalign_q <= 1'b0;
`endif
         if (redirect) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state_q <= REQ;
            drop_q  <= in_req && !imem.imem_ack;
            if (!drop_q)
               drop_addr_q <= fetch_pc_q;
`ifdef PC_FETCH_MISALIGN_EN
            wait_q <= 1'b0;
            if (misalign) begin
               // Abandon any in-flight request and park until re-steered.
               state_q    <= IDLE;
               drop_q     <= 1'b0;
               misalign_q <= 1'b1;
               wait_q     <= 1'b1;
            end
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (!Stall) begin
                     valid_q <= 1'b0;
                     instr_q <= NOP_INSTR;
                  end
`ifdef PC_FETCH_MISALIGN_EN
                  if (!wait_q)
                     state_q <= REQ;
`else
                  state_q <= REQ;
`endif
               end
               REQ: begin
                  if (imem.imem_ack) begin
                     if (drop_q) begin
                        drop_q <= 1'b0;
                        if (!Stall) begin
                           valid_q <= 1'b0;
                           instr_q <= NOP_INSTR;
                        end
                     end else if (Stall) begin
                        buf_pc_q    <= fetch_pc_q;
                        buf_instr_q <= imem.imem_rdata;
                        state_q     <= HOLD;
                     end else begin
                        pc_q    <= fetch_pc_q;
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                     end
                  end else if (!Stall) begin
                     valid_q <= 1'b0;
                     instr_q <= NOP_INSTR;
                  end
               end
               HOLD: begin
                  if (!Stall) begin
                     pc_q    <= buf_pc_q;
                     instr_q <= buf_instr_q;
                     valid_q <= 1'b1;
                     state_q <= REQ;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch. Memory returns addr ^ 32'hA5A5_0000 after
// mem_wait idle cycles of an active request.
module tb_pc_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] SALT = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        Stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        csr_flush;
   logic [31:0] csr_target;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        fetch_valid;
`ifdef PC_FETCH_MISALIGN_EN
   logic        fetch_misalign;
`endif

   int checks = 0;
   int errors = 0;
   int mem_wait = 0;
   int mem_cnt = 0;

   pc_fetch_if imem ();

   pc_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .Stall          (Stall),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .csr_flush      (csr_flush),
      .csr_target     (csr_target),
      .imem           (imem),
`ifdef PC_FETCH_MISALIGN_EN
      .fetch_misalign (fetch_misalign),
`endif
      .PC             (PC),
      .Instruction    (Instruction),
      .fetch_valid    (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      imem.imem_ack   = imem.imem_req && (mem_cnt >= mem_wait);
      imem.imem_rdata = imem.imem_addr ^ SALT;
   end

   always @(posedge clk) begin
      if (!imem.imem_req || imem.imem_ack)
         mem_cnt <= 0;
      else
         mem_cnt <= mem_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b0; Stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      csr_flush = 1'b0; csr_target = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req",   {31'h0, imem.imem_req}, 32'h0);
      chk("rst_pc",    PC, 32'h0);
      chk("rst_instr", Instruction, NOP);
      chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
      rst = 1'b1;

      // Sequential fetch, zero-wait memory
      @(negedge clk);
      chk("seq_req0",  {31'h0, imem.imem_req}, 32'h1);
      chk("seq_addr0", imem.imem_addr, 32'h0);
      chk("seq_bub0",  {31'h0, fetch_valid}, 32'h0);
      @(negedge clk);
      chk("seq_pc0",    PC, 32'h0);
      chk("seq_instr0", Instruction, 32'hA5A5_0000);
      chk("seq_valid0", {31'h0, fetch_valid}, 32'h1);
      chk("seq_addr4",  imem.imem_addr, 32'h4);
      @(negedge clk);
      chk("seq_pc4",   PC, 32'h4);
      chk("seq_addr8", imem.imem_addr, 32'h8);
      @(negedge clk);
      chk("seq_pc8",   PC, 32'h8);
      chk("seq_addrc", imem.imem_addr, 32'hC);

      // Stall for three cycles at PC 8
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_pc",    PC, 32'h8);
         chk("stall_valid", {31'h0, fetch_valid}, 32'h1);
         chk("stall_req",   {31'h0, imem.imem_req}, 32'h0);
      end
      Stall = 1'b0;
      @(negedge clk);
      chk("unstall_pc12",    PC, 32'hC);
      chk("unstall_instr12", Instruction, 32'hA5A5_000C);
      chk("unstall_valid",   {31'h0, fetch_valid}, 32'h1);
      chk("unstall_addr16",  imem.imem_addr, 32'h10);
      @(negedge clk);
      chk("unstall_pc16", PC, 32'h10);

      // Run up to a slow request at 0x20, then branch while it is pending
      repeat (3) @(negedge clk);
      chk("pre_br_pc",   PC, 32'h1C);
      chk("pre_br_addr", imem.imem_addr, 32'h20);
      mem_wait = 2;
      @(negedge clk);
      chk("slow_bubble", {31'h0, fetch_valid}, 32'h0);
      chk("slow_addr",   imem.imem_addr, 32'h20);
      br_taken = 1'b1; br_target = 32'h100;
      @(negedge clk);
      br_taken = 1'b0;
      chk("drop_addr_held", imem.imem_addr, 32'h20);
      chk("drop_req",       {31'h0, imem.imem_req}, 32'h1);
      chk("drop_bubble",    Instruction, NOP);
      @(negedge clk);
      chk("drop_discard_valid", {31'h0, fetch_valid}, 32'h0);
      chk("br_addr",            imem.imem_addr, 32'h100);
      mem_wait = 0;
      @(negedge clk);
      chk("br_pc",    PC, 32'h100);
      chk("br_instr", Instruction, 32'hA5A5_0100);
      chk("br_valid", {31'h0, fetch_valid}, 32'h1);

      // csr_flush beats br_taken, and both override Stall
      Stall = 1'b1;
      csr_flush = 1'b1; csr_target = 32'h200;
      br_taken  = 1'b1; br_target  = 32'h100;
      @(negedge clk);
      csr_flush = 1'b0; br_taken = 1'b0; Stall = 1'b0;
      chk("prio_addr",  imem.imem_addr, 32'h200);
      chk("prio_valid", {31'h0, fetch_valid}, 32'h0);
      chk("prio_instr", Instruction, NOP);
      @(negedge clk);
      chk("prio_pc", PC, 32'h200);

      // Address wrap at the top of memory
      br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
      @(negedge clk);
      br_taken = 1'b0;
      chk("wrap_addr_f8", imem.imem_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      chk("wrap_addr_fc", imem.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_addr_0",  imem.imem_addr, 32'h0);
      chk("wrap_pc",      PC, 32'hFFFF_FFFC);
      chk("wrap_instr",   Instruction, 32'h5A5A_FFFC);

`ifdef PC_FETCH_MISALIGN_EN
      br_taken = 1'b1; br_target = 32'h102;
      @(negedge clk);
      br_taken = 1'b0;
      chk("mis_pulse", {31'h0, fetch_misalign}, 32'h1);
      chk("mis_req",   {31'h0, imem.imem_req}, 32'h0);
      repeat (2) begin
         @(negedge clk);
         chk("mis_pulse_end", {31'h0, fetch_misalign}, 32'h0);
         chk("mis_park_req",  {31'h0, imem.imem_req}, 32'h0);
      end
      br_taken = 1'b1; br_target = 32'h300;
      @(negedge clk);
      br_taken = 1'b0;
      chk("mis_resume_addr", imem.imem_addr, 32'h300);
      chk("mis_resume_req",  {31'h0, imem.imem_req}, 32'h1);
`else
      br_taken = 1'b1; br_target = 32'h102;
      @(negedge clk);
      br_taken = 1'b0;
      chk("align_addr",  imem.imem_addr, 32'h100);
      chk("align_valid", {31'h0, fetch_valid}, 32'h0);
`endif

      // Reset in the middle of a pending request
      mem_wait = 2;
      @(negedge clk);
      chk("mid_pending_req", {31'h0, imem.imem_req}, 32'h1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req",   {31'h0, imem.imem_req}, 32'h0);
      chk("mid_rst_pc",    PC, 32'h0);
      chk("mid_rst_instr", Instruction, NOP);
      chk("mid_rst_valid", {31'h0, fetch_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      mem_wait = 0;
      @(negedge clk);
      chk("rerun_addr",  imem.imem_addr, 32'h0);
      chk("rerun_req",   {31'h0, imem.imem_req}, 32'h1);
      chk("rerun_valid", {31'h0, fetch_valid}, 32'h0);
      @(negedge clk);
      chk("rerun_pc",    PC, 32'h0);
      chk("rerun_instr", Instruction, 32'hA5A5_0000);
      chk("rerun_v",     {31'h0, fetch_valid}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
